gcd_stream: RTL and testbench

Parametrised binary (Stein) GCD engine with valid/ready streaming handshakes on input and output. It is the next-generation replacement for the enable/done GCD unit. Operands are accepted from an upstream producer and the result is held until a downstream consumer takes it. Datapath and FSM sit in one module; it instantiates directly into the GCD subsystem top.

---
 rtl/gcd_stream.sv | 147 ++++++++++++++
 tb/tb_gcd_stream.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gcd_stream.sv
// Binary (Stein) GCD engine with valid/ready handshakes on operands and result.
// Define GCD_CYCLE_COUNT_EN to add the cycles_o latency counter output.
module gcd_stream #(
    parameter int DATA_WIDTH  = 16,
    parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH) + 1,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  abort_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] gcd_o
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  cycles_o
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SHIFT   = 2'd1;
    localparam logic [1:0] COMPUTE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    if (DATA_WIDTH < 2 || CNT_WIDTH < 1) begin : g_param_check
        $error("gcd_stream: DATA_WIDTH must be >= 2 and CNT_WIDTH >= 1");
    end

    logic [1:0]             state_reg, state_next;
    logic [DATA_WIDTH-1:0]  a_reg, a_next;
    logic [DATA_WIDTH-1:0]  b_reg, b_next;
    logic [SHIFT_WIDTH-1:0] k_reg, k_next;
    logic [DATA_WIDTH-1:0]  gcd_reg, gcd_next;
    logic                   accept;

    assign in_ready_o  = (state_reg == IDLE);
    assign out_valid_o = (state_reg == DONE);
    assign gcd_o       = gcd_reg;
    // Abort wins over a simultaneous accept, so the operand pair is not consumed.
    assign accept      = in_ready_o && in_valid_i && !abort_i;

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        k_next     = k_reg;
        gcd_next   = gcd_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    a_next = operand_a_i;
                    b_next = operand_b_i;
                    k_next = '0;
                    if (operand_a_i == '0 || operand_b_i == '0) begin
                        gcd_next   = operand_a_i | operand_b_i;
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (!a_reg[0] && !b_reg[0]) begin
                    a_next = a_reg >> 1;
                    b_next = b_reg >> 1;
                    k_next = k_reg + SHIFT_WIDTH'(1);
                end else begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (a_reg == b_reg) begin
                    gcd_next   = a_reg << k_reg;
                    state_next = DONE;
                end else if (!a_reg[0]) begin
                    a_next = a_reg >> 1;
                end else if (!b_reg[0]) begin
                    b_next = b_reg >> 1;
                end else if (a_reg > b_reg) begin
                    a_next = (a_reg - b_reg) >> 1;
                end else begin
                    b_next = (b_reg - a_reg) >> 1;
                end
            end
            DONE: begin
                if (abort_i || out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            k_reg     <= '0;
            gcd_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            k_reg     <= k_next;
            gcd_reg   <= gcd_next;
        end
    end

`ifdef GCD_CYCLE_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_inc;
    logic [CNT_WIDTH-1:0] cycles_reg;
    logic                 busy;
    logic                 enter_done;

    assign busy       = (state_reg == SHIFT) || (state_reg == COMPUTE);
    assign enter_done = (state_next == DONE) && (state_reg != DONE);
    assign cnt_inc    = (cnt_reg == {CNT_WIDTH{1'b1}}) ? cnt_reg : cnt_reg + CNT_WIDTH'(1);
    assign cycles_o   = cycles_reg;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            cnt_reg    <= '0;
            cycles_reg <= '0;
        end else begin
            if (accept) begin
                cnt_reg <= '0;
            end else if (busy) begin
                cnt_reg <= cnt_inc;
            end
            // A zero operand finishes in the accept cycle itself, reported as 1.
            if (enter_done) begin
                cycles_reg <= (state_reg == IDLE) ? CNT_WIDTH'(1) : cnt_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gcd_stream.sv
// Directed self-checking bench for gcd_stream with hand-computed GCD vectors.
// Build with GCD_CYCLE_COUNT_EN defined to also check cycles_o.
module tb_gcd_stream;
    localparam int DW      = 16;
    localparam int CW      = 8;
    localparam int LAT_MAX = 3 * DW + 2;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] operand_a = '0;
    logic [DW-1:0] operand_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] gcd;
`ifdef GCD_CYCLE_COUNT_EN
    logic [CW-1:0] cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gcd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i       (clk),
        .nreset_i    (nreset),
        .abort_i     (abort),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .operand_a_i (operand_a),
        .operand_b_i (operand_b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .gcd_o       (gcd)
`ifdef GCD_CYCLE_COUNT_EN
        ,
        .cycles_o    (cycles)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("check %-22s got %0d expected %0d ok", tag, obs, exp);
        end else begin
            $display("FAIL %-22s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid  = 1'b1;
        operand_a = a;
        operand_b = b;
        tick();
        in_valid  = 1'b0;
        // Garbage on the operand bus must not disturb the running computation.
        operand_a = '1;
        operand_b = 16'h5A5A;
    endtask

    // Latency counts the accept edge as cycle 1.
    task automatic wait_valid(input string tag, output int lat);
        lat = 1;
        while (!out_valid && lat <= LAT_MAX + 1) begin
            tick();
            lat++;
        end
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] exp_gcd, input bit exact_one, input int exp_cyc);
        int lat;
        out_ready = 1'b1;
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        accept(a, b);
        wait_valid(tag, lat);
        check_val({tag, "_gcd"}, 32'(gcd), 32'(exp_gcd));
        if (exact_one) check_val({tag, "_lat1"}, 32'(lat), 32'd1);
        else           check_val({tag, "_lat_bound"}, 32'(lat <= LAT_MAX), 32'd1);
`ifdef GCD_CYCLE_COUNT_EN
        if (exp_cyc >= 0) check_val({tag, "_cycles"}, 32'(cycles), 32'(exp_cyc));
`endif
        tick();
        check_val({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check_val({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        bit seen;

        tick();
        tick();
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_gcd", 32'(gcd), 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
        check_val("rst_cycles", 32'(cycles), 32'd0);
`endif
        nreset = 1'b1;
        tick();

        run_op("g48_18", 16'd48, 16'd18, 16'd6, 1'b0, 7);
        run_op("z0_0", 16'd0, 16'd0, 16'd0, 1'b1, 1);
        run_op("z0_35", 16'd0, 16'd35, 16'd35, 1'b1, 1);
        run_op("z35_0", 16'd35, 16'd0, 16'd35, 1'b1, 1);
        run_op("k14", 16'd32768, 16'd49152, 16'd16384, 1'b0, 18);
        run_op("coprime", 16'd65521, 16'd65519, 16'd1, 1'b0, -1);

        // Backpressure: result held while the consumer stalls.
        out_ready = 1'b0;
        accept(16'd65535, 16'd4096);
        wait_valid("bp", lat);
        check_val("bp_gcd", 32'(gcd), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("bp_hold_gcd", 32'(gcd), 32'd1);
            check_val("bp_hold_valid", 32'(out_valid), 32'd1);
            check_val("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check_val("bp_release_ready", 32'(in_ready), 32'd1);
        check_val("bp_release_valid", 32'(out_valid), 32'd0);
        check_val("bp_gcd_kept", 32'(gcd), 32'd1);

        // Abort while still shifting out common powers of two.
        accept(16'd32768, 16'd49152);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_shift_valid", 32'(out_valid), 32'd0);
        check_val("abort_shift_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < LAT_MAX + 10; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check_val("abort_shift_no_out", 32'(seen), 32'd0);
        check_val("abort_shift_gcd", 32'(gcd), 32'd1);

        // Abort while the result waits for the consumer.
        out_ready = 1'b0;
        accept(16'd12, 16'd8);
        wait_valid("abort_done", lat);
        check_val("abort_done_gcd", 32'(gcd), 32'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_done_valid", 32'(out_valid), 32'd0);
        check_val("abort_done_ready", 32'(in_ready), 32'd1);

        // Abort together with in_valid: the pair must not be taken.
        abort     = 1'b1;
        in_valid  = 1'b1;
        operand_a = 16'd0;
        operand_b = 16'd35;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check_val("abort_idle_ready", 32'(in_ready), 32'd1);
        check_val("abort_idle_valid", 32'(out_valid), 32'd0);
        tick();
        check_val("abort_idle_valid2", 32'(out_valid), 32'd0);
        check_val("abort_idle_gcd", 32'(gcd), 32'd4);

        // Asynchronous reset in the middle of COMPUTE.
        out_ready = 1'b1;
        accept(16'd48, 16'd18);
        tick();
        tick();
        tick();
        nreset = 1'b0;
        #1;
        check_val("arst_valid", 32'(out_valid), 32'd0);
        check_val("arst_ready", 32'(in_ready), 32'd1);
        check_val("arst_gcd", 32'(gcd), 32'd0);
        tick();
        nreset = 1'b1;
        tick();
        check_val("arst_after_valid", 32'(out_valid), 32'd0);
        run_op("post_rst", 16'd12, 16'd8, 16'd4, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global guard so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "simulation time limit reached");
    end

endmodule
